// File: rtl/rds_group_encoder.sv
// rds_group_encoder: RDS group-0A encoder writing checkworded 26-bit blocks packed into RAM bytes; RDS_RT_EN adds group-2A radiotext
module rds_group_encoder #(
    parameter int unsigned C_BASE_ADDR = 0,
    parameter int unsigned C_ADDR_BITS = 9,
    parameter logic [15:0] C_AF_WORD   = 16'hE0CD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            pi,
    input  logic [4:0]             pty,
    input  logic                   tp,
    input  logic                   ta,
    input  logic                   ms,
    input  logic                   ps_we,
`ifdef RDS_RT_EN
    input  logic [5:0]             ps_addr,
`else
    input  logic [2:0]             ps_addr,
`endif
    input  logic [7:0]             ps_data,
    output logic                   wr_en,
    output logic [C_ADDR_BITS-1:0] wr_addr,
    output logic [7:0]             wr_data,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRC, S_EMIT, S_NEXT, S_DONE} state_t;
    localparam logic [C_ADDR_BITS-1:0] BASE = C_ADDR_BITS'(C_BASE_ADDR);
`ifdef RDS_RT_EN
    localparam logic [4:0] LAST_SEG = 5'd19;
`else
    localparam logic [4:0] LAST_SEG = 5'd3;
`endif
    state_t                 st_q;
    logic [4:0]             seg_q;
    logic [1:0]             blk_q;
    logic [4:0]             cnt_q;
    logic [25:0]            sh_q;
    logic [9:0]             crc_q;
    logic [9:0]             crc_nx;
    logic [7:0]             sb_q;
    logic [2:0]             bc_q;
    logic [15:0]            pi_q;
    logic [4:0]             pty_q;
    logic                   tp_q, ta_q, ms_q;
    logic                   wr_en_q, busy_q, done_q;
    logic [C_ADDR_BITS-1:0] wr_addr_q;
    logic [7:0]             wr_data_q;
    logic [7:0]             ps_q [8];
    logic [15:0]            word_d, w0a;
    logic [9:0]             off_d;
`ifdef RDS_RT_EN
    logic [7:0]             rt_q [64];
    logic [3:0]             s2a;
    logic [15:0]            w2a;
`endif

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Character buffers: written from the CPU side at any time, cleared to spaces on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) ps_q[i] <= 8'h20;
`ifdef RDS_RT_EN
            for (int i = 0; i < 64; i++) rt_q[i] <= 8'h20;
`endif
        end else if (ps_we) begin
`ifdef RDS_RT_EN
            if (ps_addr[5:3] == 3'd0) ps_q[ps_addr[2:0]] <= ps_data;
            else rt_q[ps_addr] <= ps_data;
`else
            ps_q[ps_addr] <= ps_data;
`endif
        end
    end

    // Block word, offset word and one serial CRC step for the current block
    always_comb begin
        w0a = blk_q == 2'd0 ? pi_q :
              blk_q == 2'd1 ? {5'b00000, tp_q, pty_q, ta_q, ms_q, 1'b0, seg_q[1:0]} :
              blk_q == 2'd2 ? C_AF_WORD : {ps_q[{seg_q[1:0], 1'b0}], ps_q[{seg_q[1:0], 1'b1}]};
`ifdef RDS_RT_EN
        s2a = 4'(seg_q - 5'd4);
        w2a = blk_q == 2'd0 ? pi_q :
              blk_q == 2'd1 ? {4'b0010, 1'b0, tp_q, pty_q, 1'b0, s2a} :
              blk_q == 2'd2 ? {rt_q[{s2a, 2'd0}], rt_q[{s2a, 2'd1}]} : {rt_q[{s2a, 2'd2}], rt_q[{s2a, 2'd3}]};
        word_d = seg_q >= 5'd4 ? w2a : w0a;
`else
        word_d = w0a;
`endif
        off_d  = blk_q == 2'd0 ? 10'h0FC : blk_q == 2'd1 ? 10'h198 : blk_q == 2'd2 ? 10'h168 : 10'h1B4;
        crc_nx = {crc_q[8:0], 1'b0} ^ ((crc_q[9] ^ sh_q[25]) ? 10'h1B9 : 10'h000);
    end

    // Sequencer: load block, 16 CRC steps while rotating info, 26 emit steps into the byte packer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= S_IDLE;
            seg_q     <= 5'd0;
            blk_q     <= 2'd0;
            cnt_q     <= 5'd0;
            sh_q      <= 26'd0;
            crc_q     <= 10'd0;
            sb_q      <= 8'd0;
            bc_q      <= 3'd0;
            pi_q      <= 16'd0;
            pty_q     <= 5'd0;
            tp_q      <= 1'b0;
            ta_q      <= 1'b0;
            ms_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE;
            wr_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (wr_en_q) wr_addr_q <= wr_addr_q + C_ADDR_BITS'(1);
            case (st_q)
                S_IDLE: if (start) begin
                    pi_q      <= pi;
                    pty_q     <= pty;
                    tp_q      <= tp;
                    ta_q      <= ta;
                    ms_q      <= ms;
                    seg_q     <= 5'd0;
                    blk_q     <= 2'd0;
                    bc_q      <= 3'd0;
                    wr_addr_q <= BASE;
                    busy_q    <= 1'b1;
                    st_q      <= S_LOAD;
                end
                S_LOAD: begin
                    sh_q  <= {word_d, 10'h000};
                    crc_q <= 10'd0;
                    cnt_q <= 5'd0;
                    st_q  <= S_CRC;
                end
                S_CRC: begin
                    crc_q <= crc_nx;
                    sh_q  <= {sh_q[24:10], sh_q[25], cnt_q == 5'd15 ? crc_nx ^ off_d : 10'h000};
                    cnt_q <= cnt_q == 5'd15 ? 5'd0 : cnt_q + 5'd1;
                    st_q  <= cnt_q == 5'd15 ? S_EMIT : S_CRC;
                end
                S_EMIT: begin
                    sb_q  <= {sb_q[6:0], sh_q[25]};
                    sh_q  <= {sh_q[24:0], 1'b0};
                    bc_q  <= bc_q + 3'd1;
                    cnt_q <= cnt_q + 5'd1;
                    st_q  <= cnt_q == 5'd25 ? S_NEXT : S_EMIT;
                    if (bc_q == 3'd7) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= {sb_q[6:0], sh_q[25]};
                    end
                end
                S_NEXT: begin
                    blk_q <= blk_q + 2'd1;
                    st_q  <= S_LOAD;
                    if (blk_q == 2'd3) begin
                        if (seg_q == LAST_SEG) begin
                            st_q   <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            seg_q <= seg_q + 5'd1;
                        end
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rds_group_encoder.sv
// tb_rds_group_encoder: randomized scoreboard bench for rds_group_encoder (RDS_RT_EN aware)
module tb_rds_group_encoder;
`ifdef RDS_RT_EN
    localparam int NGRP = 20;
    localparam int PSA  = 6;
`else
    localparam int NGRP = 4;
    localparam int PSA  = 3;
`endif
    localparam int NB  = NGRP * 13;
    localparam int CYC = NGRP * 176;
    localparam logic [9:0] OFS [4] = '{10'h0FC, 10'h198, 10'h168, 10'h1B4};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [15:0]    pi = 16'h0;
    logic [4:0]     pty = 5'h0;
    logic           tp = 1'b0, ta = 1'b0, ms = 1'b0;
    logic           ps_we = 1'b0;
    logic [PSA-1:0] ps_addr = '0;
    logic [7:0]     ps_data = 8'h0;
    logic           wr_en;
    logic [8:0]     wr_addr;
    logic [7:0]     wr_data;
    logic           busy, done;

    int total = 0, bad = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic [16:0] sb [$];
    logic [7:0]  cap [512];
    logic [7:0]  exp_ps [8];
    logic [7:0]  exp_rt [64];

    rds_group_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pi(pi), .pty(pty), .tp(tp), .ta(ta), .ms(ms),
        .ps_we(ps_we), .ps_addr(ps_addr), .ps_data(ps_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                logic [16:0] e;
                wr_cnt++;
                cap[wr_addr] = wr_data;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL extra_write: addr=%0d data=%h with nothing expected", wr_addr, wr_data);
                end else begin
                    e = sb.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        bad++;
                        $display("FAIL byte: got addr=%0d data=%h want addr=%0d data=%h", wr_addr, wr_data, e[16:8], e[7:0]);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic push_expected();
        bit bits [$];
        logic [15:0] info;
        logic [25:0] r, blk;
        logic [7:0]  by;
        int v;
        for (int g = 0; g < NGRP; g++) begin
            for (int b = 0; b < 4; b++) begin
                if (g < 4) begin
                    v = int'(tp) * 1024 + int'(pty) * 32 + int'(ta) * 16 + int'(ms) * 8 + g;
                    info = b == 0 ? pi : b == 1 ? 16'(v) : b == 2 ? 16'hE0CD : {exp_ps[2*g], exp_ps[2*g+1]};
                end else begin
                    v = 16'h2000 + int'(tp) * 1024 + int'(pty) * 32 + (g - 4);
                    info = b == 0 ? pi : b == 1 ? 16'(v) : b == 2 ? {exp_rt[4*(g-4)], exp_rt[4*(g-4)+1]}
                                                            : {exp_rt[4*(g-4)+2], exp_rt[4*(g-4)+3]};
                end
                r = {info, 10'h000};
                for (int i = 25; i >= 10; i--) if (r[i]) r = r ^ (26'h5B9 << (i - 10));
                blk = {info, r[9:0] ^ OFS[b]};
                for (int i = 25; i >= 0; i--) bits.push_back(blk[i]);
            end
        end
        for (int n = 0; n < NB; n++) begin
            by = 8'h0;
            for (int j = 0; j < 8; j++) by = {by[6:0], bits[8*n+j]};
            sb.push_back({9'(n), by});
        end
    endtask

    task automatic ps_write(input int a, input logic [7:0] d);
        @(negedge clk);
        ps_we = 1'b1; ps_addr = PSA'(a); ps_data = d;
        @(negedge clk);
        ps_we = 1'b0;
        if (a < 8) exp_ps[a] = d;
        else exp_rt[a] = d;
    endtask

    task automatic run(input int rep_at, input int psw_at, input int rst_at);
        int s0;
        wr_cnt = 0; done_cnt = 0;
        push_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; s0 = cyc;
        chk("busy_on", 32'(busy), 32'd1);
        for (int k = 1; k <= CYC + 20; k++) begin
            @(negedge clk);
            start   = (k == rep_at);
            ps_we   = (k == psw_at) || (k == psw_at + 1);
            ps_addr = (k == psw_at) ? PSA'(0) : PSA'(7);
            ps_data = (k == psw_at) ? "X" : "Y";
            if (k == rst_at) begin
                ps_we = 1'b0;
                #5 rst_n = 1'b0;
                #1;
                chk("rst_wr_en", 32'(wr_en), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_wr_addr", 32'(wr_addr), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                return;
            end
        end
        start = 1'b0; ps_we = 1'b0;
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_latency", 32'(done_cyc - s0), 32'(CYC));
        chk("write_count", 32'(wr_cnt), 32'(NB));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("busy_off", 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] block_info(input int idx);
        logic [15:0] d = 16'h0;
        for (int i = 0; i < 16; i++) d = {d[14:0], cap[(idx*26+i)/8][7-((idx*26+i)%8)]};
        return d;
    endfunction

    initial begin
        string nm;
        nm = "RADIO 01";
        for (int i = 0; i < 8; i++) exp_ps[i] = 8'h20;
        for (int i = 0; i < 64; i++) exp_rt[i] = 8'h20;
        @(negedge clk);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        pi = 16'h0000;
        run(-1, -1, -1);
        chk("pi0_b0", 32'(cap[0]), 32'h00);
        chk("pi0_b1", 32'(cap[1]), 32'h00);
        chk("pi0_b2", 32'(cap[2]), 32'h3F);
        chk("pi0_b3_top", 32'(cap[3][7:6]), 32'd0);

        pi = 16'h0001;
        run(-1, -1, -1);
        chk("pi1_b1", 32'(cap[1]), 32'h01);
        chk("pi1_b2", 32'(cap[2]), 32'h51);

        for (int i = 0; i < 8; i++) ps_write(i, nm[i]);
        pi = 16'hC201;
        run(-1, -1, -1);
        chk("seg2_b4", 32'(block_info(11)), 32'h4F20);

        pi = 16'(($urandom));
        run(100, -1, -1);

        exp_ps[7] = "Y";
        run(-1, 200, -1);
        exp_ps[0] = "X";

        for (int t = 0; t < 3; t++) begin
            pi = 16'($urandom); pty = 5'($urandom); tp = 1'($urandom); ta = 1'($urandom); ms = 1'($urandom);
            for (int i = 0; i < 8; i++) ps_write(i, 8'($urandom_range(32, 126)));
`ifdef RDS_RT_EN
            for (int i = 0; i < 6; i++) ps_write(int'($urandom_range(8, 63)), 8'($urandom_range(32, 126)));
`endif
            run(-1, -1, -1);
        end

        pi = 16'h1234;
        run(-1, -1, 300);
        sb.delete();
        for (int i = 0; i < 8; i++) exp_ps[i] = 8'h20;
        for (int i = 0; i < 64; i++) exp_rt[i] = 8'h20;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pi = 16'hA5C3;
        run(-1, -1, -1);
        chk("after_reset_b0", 32'(cap[0]), 32'hA5);
`ifdef RDS_RT_EN
        chk("rt_group_pi", 32'(cap[52]), 32'(cap[0]));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rds_group_encoder.md
Name: rds_group_encoder

Overview:
- Builds RDS group-0A baseband data (PI, PTY, TP/TA/MS, 8-char PS name) with 10-bit checkwords and offset words.
- Packs the 26-bit blocks MSB-first into bytes and writes them into the RDS message RAM.
- The RDS mixer/modulator stage reads that RAM cyclically, so this block sits directly upstream of it and replaces the current constant-zero CPU write path.

Parameters:
- C_BASE_ADDR, 0, first RAM byte address written.
- C_ADDR_BITS, 9, RAM address width.
- C_AF_WORD, 16'hE0CD, block-3 content of every 0A group ("no AF" plus filler).

Ports:
- clk  in  1  system clock (25 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle strobe; begin encoding a full message.
- pi  in  16  program identification.
- pty  in  5  program type.
- tp  in  1  traffic program flag.
- ta  in  1  traffic announcement flag.
- ms  in  1  music/speech flag.
- ps_we  in  1  PS character write enable.
- ps_addr  in  3  PS character index 0..7 (6 bits with RDS_RT_EN, see below).
- ps_data  in  8  PS character.
- wr_en  out  1  RAM byte write strobe.
- wr_addr  out  C_ADDR_BITS  RAM byte address.
- wr_data  out  8  RAM byte.
- busy  out  1  encoding in progress.
- done  out  1  one-cycle pulse after the final byte write.

Behaviour:
- Reset values:
  - wr_en=0, wr_addr=C_BASE_ADDR, wr_data=0, busy=0, done=0.
  - PS buffer = 8 x 8'h20 (space).
  - FSM in IDLE; CRC register and bit counters cleared.
- PS buffer:
  - ps_we writes ps_data at ps_addr on the rising edge, accepted in any state.
  - A character is sampled when its block-4 LOAD occurs. A write landing before that LOAD is visible in the current run; a later write is not.
- start:
  - Accepted only in IDLE.
  - On acceptance, pi/pty/tp/ta/ms are snapshotted, busy=1 from the next cycle, and the segment counter is cleared.
  - start while busy is ignored, with no restart.
- Block contents for segment s (0..3):
  - B1 = pi, offset A = 10'h0FC.
  - B2 = {4'b0000, 1'b0, tp, pty, ta, ms, 1'b0 (DI), s[1:0]}, offset B = 10'h198.
  - B3 = C_AF_WORD, offset C = 10'h168.
  - B4 = {ps[2s], ps[2s+1]}, offset D = 10'h1B4.
- Checkword:
  - Remainder of info*x^10 mod g(x) = x^10+x^8+x^7+x^5+x^4+x^3+1 (10'h1B9 feedback), XOR offset.
  - Computed bit-serially, info MSB first.
- FSM:
  - IDLE -> LOAD on start.
  - LOAD, 1 cycle: select the block word, clear CRC.
  - CRC, 16 cycles.
  - EMIT, 26 cycles: shift {info, check} MSB-first into the byte assembler, 1 bit per cycle.
  - NEXT, 1 cycle: advance block, then segment.
  - After the last block, NEXT -> DONE (1 cycle, done=1, busy drops) -> IDLE.
- Byte packing:
  - The byte assembler persists across block boundaries; 26-bit blocks are not byte-aligned, but each 104-bit group ends byte-aligned.
  - wr_en pulses one cycle when the 8th bit enters. wr_data holds that byte.
  - wr_addr increments after each write.
- Cycle counts:
  - 44 cycles per block.
  - 4 groups = 52 bytes, 704 cycles start->done.
- Reset mid-run: everything aborts immediately to reset values, including the PS buffer. A partial message is left in RAM.

Optional Feature:
- Macro: RDS_RT_EN.
- Defined:
  - Adds a 64-byte radiotext buffer (reset to spaces) and 16 group-2A segments after the 4 PS groups.
  - ps_addr widens to 6 bits: with ps_addr[5:3]==0 the write targets the PS buffer; otherwise it targets RT chars 0..63 at index ps_addr.
  - 2A blocks:
    - B1 = pi.
    - B2 = {4'b0010, 1'b0, tp, pty, 1'b0 (A/B flag), s[3:0]}.
    - B3 = rt[4s], rt[4s+1].
    - B4 = rt[4s+2], rt[4s+3].
    - Offsets as above.
  - Totals: 20 groups = 260 bytes, 3520 cycles.
- Undefined: PS only, 52 bytes; ps_addr is 3 bits.

Test Plan:
- Reset, then pi=16'h0000, start: first three writes at addr 0,1,2 = 8'h00, 8'h00, 8'h3F; the 4th byte's top two bits = 2'b00.
- pi=16'h0001, start: bytes 0..2 = 8'h00, 8'h01, 8'h51 (checkword 10'h145).
- PS="RADIO 01", default flags: exactly 52 wr_en pulses at addr 0..51; done pulses exactly once, 704 cycles after start; decoded B4 of segment 2 = 16'h4F20.
- start re-pulsed at cycle 100 while busy: the output byte stream is identical to an undisturbed run; still 52 writes.
- rst_n low at cycle 300: wr_en=0, busy=0, wr_addr=C_BASE_ADDR immediately. A new start re-encodes from address 0 with PS reset to spaces.
- RDS_RT_EN defined: 260 writes, done at cycle 3520; byte 52 begins group 2A with the same PI byte as byte 0.
